perimeter_chaser: RTL
=====================

# perimeter_chaser

Sequential successor to the team's static perimeter-step segment decoder. It generates its own step position with a programmable prescaler, runs clockwise or counter-clockwise, and lights a trail of 1–3 segments around the outer ring of two N-digit seven-segment banks. Digits are time-multiplexed so that several lit segments can share one bank. It sits between the board clock and the left/right display banks.

## Interface
- DIGITS, 4: digits per bank, ≥1; ring length PERIM = 4*DIGITS+4.
- STEP_DIV, 50_000_000: clk cycles per step, ≥1.
- SCAN_DIV, 50_000: clk cycles per scan slot, ≥1.
- clk  in  1  system clock; one clock domain only.
- rst  in  1  synchronous, active-high reset.
- en  in  1  1 = advance the step; 0 = freeze the step while scanning continues.
- dir  in  1  0 = clockwise (step increments); 1 = counter-clockwise (step decrements).
- tail  in  2  number of lit segments; 0 is treated as 1; 3 is the maximum.
- a_to_g_left  out  8  left bank segments, active-high; bit7=a, 6=b, 5=c, 4=d, 3=e, 2=f, 1=g, 0=dp.
- a_to_g_right  out  8  right bank segments; same encoding.
- leftseg  out  DIGITS  left bank digit enables, active-high; MSB is the leftmost digit.
- rightseg  out  DIGITS  right bank digit enables; MSB is the leftmost digit.
- step  out  $clog2(PERIM)  current head position.
- wrap  out  1  one-cycle pulse when the head wraps around.

## Operation
- **Ring mapping** for position p, with N=DIGITS:
  - p = 0..N-1: left bank, seg a, digit bit N-1-p.
  - p = N..2N-1: right bank, seg a, digit bit 2N-1-p.
  - p = 2N: right bank, seg b, bit 0.
  - p = 2N+1: right bank, seg c, bit 0.
  - p = 2N+2..3N+1: right bank, seg d, bit p-(2N+2).
  - p = 3N+2..4N+1: left bank, seg d, bit p-(3N+2).
  - p = 4N+2: left bank, seg e, bit N-1.
  - p = 4N+3: left bank, seg f, bit N-1.
- **Prescaler:** counts 0..STEP_DIV-1 while en=1, then produces a one-cycle tick. When en=0 the prescaler holds.
- **Step update on tick:**
  - dir=0: step = (step+1) mod PERIM.
  - dir=1: step = (step-1) mod PERIM.
  - dir is sampled on the tick cycle only.
- **wrap:** asserted in the cycle after a PERIM-1→0 transition (dir=0) or a 0→PERIM-1 transition (dir=1).
- **Trail:** the lit set is the head plus the positions behind it relative to the current dir, L = max(tail,1) positions in total:
  - dir=0: head−k mod PERIM, for k = 0..L-1.
  - dir=1: head+k mod PERIM, for k = 0..L-1.
- **Scan:** a slot counter i = 0..N-1 advances every SCAN_DIV cycles and wraps from N-1 to 0.
  - Slot i drives left and right digit bit N-1-i in parallel.
  - Each bank's segment bus carries the OR of all lit segments mapped to that bank and digit.
  - A bank's digit enable is one-hot only if its segment bus is nonzero; otherwise the enable and the segments are all 0.
- Segments g and dp are always 0.

## Timing
- Reset values: step=0, prescaler=0, slot=0, wrap=0, all segment and enable outputs 0.
- Outputs are registered. The display reflects a new step or slot one cycle after that step or slot update.
- From release of rst with en=1, the first tick occurs STEP_DIV cycles later.
- Simultaneous tick and slot advance: both take effect in the same cycle. The display combines the new step with the new slot one cycle later.
- A tail change takes effect on the next display register update; it does not wait for a tick.
- rst asserted mid-operation returns all state to its reset values on the next edge, overriding en and tick.
- A dir change between ticks flips the trail side immediately; the head moves only on the next tick.

## Structure
- Shared package holds:
  - the segment bit-index constants (SEG_A..SEG_DP);
  - a function for PERIM(DIGITS);
  - the step-width constant.
- Sub-module `perimeter_decode` (combinational): maps position, DIGITS, and scan slot to a per-bank segment mask. Instantiated once per trail element (3 instances), with the results ORed.
- Top level holds the prescaler, step counter, wrap logic, scan counter, and output registers.

## Test plan
All scenarios use DIGITS=4, STEP_DIV=4, SCAN_DIV=2.
1. **Reset:** hold rst 3 cycles → all outputs 0 and step=0. Release with en=1 → step=1 four cycles later.
2. **Clockwise lap:** tail=1, dir=0 → step visits 0..19.
   - At step 8 in the scan slot for bit0: a_to_g_right=8'b01000000, rightseg=4'b0001, left bank all 0.
   - wrap pulses once on the 19→0 transition.
3. **Counter-clockwise wrap:** dir=1 from step 0 → next tick gives step=19, left bank shows 8'b00000100 on leftseg=4'b1000, and wrap pulses.
4. **Same-digit trail:** tail=2, dir=0, step=9 → in the slot for bit0, a_to_g_right=8'b01100000 and rightseg=4'b0001.
5. **Pause:** en=0 for 20 cycles → step is constant, and leftseg/rightseg continue cycling through their slots.
6. **Mid-run reset:** assert rst at step 12 during a slot for bit2 → the next cycle has all outputs 0 and step=0.

Source files
------------

// File: rtl/perimeter_chaser_pkg.sv
// Shared definitions for the perimeter chaser.
// - SEG_A..SEG_DP: bit positions of each segment on an a_to_g bus
//   (bit7 = a ... bit1 = g, bit0 = dp).
// - perim(): ring length for a given digit count.
// - step_width(): width of the head-position counter for a given digit count.
package perimeter_chaser_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  // Outer ring: top row of both banks, right edge, bottom row of both banks, left edge.
  function automatic int perim(input int digits);
    return 4 * digits + 4;
  endfunction

  function automatic int step_width(input int digits);
    return $clog2(perim(digits));
  endfunction

endpackage

// File: rtl/perimeter_decode.sv
// Combinational ring-position decoder.
// Maps one ring position to the segment it lights, but only reports it when
// that segment lives on the digit currently selected by the scan slot.
// Ports:
//   pos_i   - ring position 0..PERIM-1
//   slot_i  - scan slot; slot i selects digit bit DIGITS-1-i
//   en_i    - 0 suppresses this trail element entirely
//   left_o  - segment mask contributed to the left bank
//   right_o - segment mask contributed to the right bank
module perimeter_decode
  import perimeter_chaser_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int SW     = step_width(DIGITS),
  parameter int SLW    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic [SW-1:0]  pos_i,
  input  logic [SLW-1:0] slot_i,
  input  logic           en_i,
  output logic [7:0]     left_o,
  output logic [7:0]     right_o
);

  always_comb begin
    int         p;
    int         bit_idx;
    logic       on_right;
    logic [2:0] seg;
    p        = int'(pos_i);
    on_right = 1'b0;
    seg      = 3'(SEG_A);
    bit_idx  = 0;
    if (p < DIGITS) begin
      bit_idx = DIGITS - 1 - p;
    end else if (p < 2 * DIGITS) begin
      on_right = 1'b1;
      bit_idx  = 2 * DIGITS - 1 - p;
    end else if (p == 2 * DIGITS) begin
      on_right = 1'b1;
      seg      = 3'(SEG_B);
    end else if (p == 2 * DIGITS + 1) begin
      on_right = 1'b1;
      seg      = 3'(SEG_C);
    end else if (p <= 3 * DIGITS + 1) begin
      on_right = 1'b1;
      seg      = 3'(SEG_D);
      bit_idx  = p - (2 * DIGITS + 2);
    end else if (p <= 4 * DIGITS + 1) begin
      seg      = 3'(SEG_D);
      bit_idx  = p - (3 * DIGITS + 2);
    end else if (p == 4 * DIGITS + 2) begin
      seg      = 3'(SEG_E);
      bit_idx  = DIGITS - 1;
    end else begin
      seg      = 3'(SEG_F);
      bit_idx  = DIGITS - 1;
    end

    left_o  = '0;
    right_o = '0;
    if (en_i && (bit_idx == DIGITS - 1 - int'(slot_i))) begin
      if (on_right) right_o[seg] = 1'b1;
      else          left_o[seg]  = 1'b1;
    end
  end

endmodule

// File: rtl/perimeter_chaser.sv
// Perimeter chaser: a head position walks around the outer ring of two
// DIGITS-wide seven-segment banks, trailed by up to two more lit segments.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   en           - 1 advances the step prescaler; 0 freezes the head
//   dir          - 0 clockwise (increment), 1 counter-clockwise (decrement)
//   tail         - trail length, 0 behaves as 1
//   a_to_g_left/right - registered segment buses (bit7=a .. bit0=dp)
//   leftseg/rightseg  - registered one-hot digit enables, MSB = leftmost
//   step         - current head position
//   wrap         - one-cycle pulse after the head crosses the 0/PERIM-1 seam
// Valid/ready: none; all inputs are level-sampled every clock.
module perimeter_chaser
  import perimeter_chaser_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int STEP_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           dir,
  input  logic [1:0]                     tail,
  output logic [7:0]                     a_to_g_left,
  output logic [7:0]                     a_to_g_right,
  output logic [DIGITS-1:0]              leftseg,
  output logic [DIGITS-1:0]              rightseg,
  output logic [step_width(DIGITS)-1:0]  step,
  output logic                           wrap
);

  localparam int PERIM = perim(DIGITS);
  localparam int SW    = step_width(DIGITS);
  localparam int SLW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int CW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0]     presc_q;
  logic [CW-1:0]     scan_q;
  logic [SLW-1:0]    slot_q;
  logic [SW-1:0]     step_q, step_d;
  logic              wrap_q, wrap_d;
  logic [7:0]        left_q, left_d, right_q, right_d;
  logic [DIGITS-1:0] lsel_q, lsel_d, rsel_q, rsel_d;
  logic [DIGITS-1:0] digit_sel;

  logic [SW-1:0]     trail_pos [3];
  logic              trail_en  [3];
  logic [7:0]        lmask     [3];
  logic [7:0]        rmask     [3];

  // Head movement and seam detection, applied only on a prescaler tick.
  always_comb begin
    step_d = step_q;
    wrap_d = 1'b0;
    if (dir) begin
      if (step_q == '0) begin
        step_d = SW'(PERIM - 1);
        wrap_d = 1'b1;
      end else begin
        step_d = step_q - SW'(1);
      end
    end else begin
      if (step_q == SW'(PERIM - 1)) begin
        step_d = '0;
        wrap_d = 1'b1;
      end else begin
        step_d = step_q + SW'(1);
      end
    end
  end

  // Trail sits behind the head relative to the current direction, so a dir
  // change flips it immediately even though the head waits for a tick.
  always_comb begin
    int s;
    int len;
    int pk;
    s   = int'(step_q);
    len = (tail == 2'd0) ? 1 : int'(tail);
    pk  = 0;
    for (int k = 0; k < 3; k++) begin
      pk           = dir ? (s + k) % PERIM : (s - k + PERIM) % PERIM;
      trail_pos[k] = SW'(pk);
      trail_en[k]  = (k < len);
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_trail
    perimeter_decode #(
      .DIGITS (DIGITS),
      .SW     (SW),
      .SLW    (SLW)
    ) u_decode (
      .pos_i   (trail_pos[k]),
      .slot_i  (slot_q),
      .en_i    (trail_en[k]),
      .left_o  (lmask[k]),
      .right_o (rmask[k])
    );
  end

  // A bank with nothing lit on the current digit is blanked entirely.
  always_comb begin
    digit_sel       = DIGITS'(1) << (DIGITS - 1 - int'(slot_q));
    left_d          = lmask[0] | lmask[1] | lmask[2];
    right_d         = rmask[0] | rmask[1] | rmask[2];
    left_d[SEG_G]   = 1'b0;
    left_d[SEG_DP]  = 1'b0;
    right_d[SEG_G]  = 1'b0;
    right_d[SEG_DP] = 1'b0;
    lsel_d          = (|left_d)  ? digit_sel : '0;
    rsel_d          = (|right_d) ? digit_sel : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      scan_q  <= '0;
      slot_q  <= '0;
      step_q  <= '0;
      wrap_q  <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      lsel_q  <= '0;
      rsel_q  <= '0;
    end else begin
      wrap_q <= 1'b0;
      if (en) begin
        if (presc_q == PW'(STEP_DIV - 1)) begin
          presc_q <= '0;
          step_q  <= step_d;
          wrap_q  <= wrap_d;
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end
      if (scan_q == CW'(SCAN_DIV - 1)) begin
        scan_q <= '0;
        slot_q <= (slot_q == SLW'(DIGITS - 1)) ? '0 : slot_q + SLW'(1);
      end else begin
        scan_q <= scan_q + CW'(1);
      end
      // Display registers sample the pre-edge step/slot, hence one cycle behind them.
      left_q  <= left_d;
      right_q <= right_d;
      lsel_q  <= lsel_d;
      rsel_q  <= rsel_d;
    end
  end

  assign a_to_g_left  = left_q;
  assign a_to_g_right = right_q;
  assign leftseg      = lsel_q;
  assign rightseg     = rsel_q;
  assign step         = step_q;
  assign wrap         = wrap_q;

endmodule
